i2c_reg_fifo_if: RTL and testbench

Avalon-MM slave front end for the I2C master serial engine on the DE1-SoC.
- Holds the slave-address and control registers.
- Buffers transmit bytes in a TX FIFO that the engine pops, and receive bytes in an RX FIFO that the engine pushes.
- Reports FIFO status to the HPS.
- Sits between the lightweight HPS bridge and the serial engine, driving its SLAVE_ADDRESS_r, control_reg and data_from_tx_fifo inputs and consuming tx_fifo_rd_en, data_to_rx_fifo and rx_fifo_wr_en.

---
 rtl/i2c_if_pkg.sv | 20 ++
 rtl/i2c_reg_fifo_if_sync_fifo.sv | 68 ++++++
 rtl/i2c_reg_fifo_if.sv | 134 +++++++++++++
 tb/tb_i2c_reg_fifo_if.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_if_pkg.sv
// rtl/i2c_if_pkg.sv - register map and bit positions for the I2C Avalon front end
package i2c_if_pkg;

    localparam logic [1:0] REG_ADDRESS = 2'd0;
    localparam logic [1:0] REG_DATA    = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CONTROL = 2'd3;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_RX_OV    = 2;
    localparam int ST_TX_EMPTY = 3;
    localparam int ST_TX_FULL  = 4;
    localparam int ST_TX_OV    = 5;
    localparam int ST_RX_COUNT = 8;
    localparam int ST_TX_COUNT = 16;

    localparam int CTRL_START_BIT = 17;

endpackage

// File: rtl/i2c_reg_fifo_if_sync_fifo.sv
// rtl/i2c_reg_fifo_if_sync_fifo.sv - synchronous FIFO with registered pop data and combinational head
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    // A pop on a full FIFO frees the slot the same-cycle push lands in
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign overflow  = push & ~w_do_push;
    assign count     = r_count;
    assign dout      = r_dout;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_reg_fifo_if.sv
// rtl/i2c_reg_fifo_if.sv - Avalon-MM register and FIFO front end for the I2C master engine
module i2c_reg_fifo_if
    import i2c_if_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic [3:0]  byteenable,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  slave_address,
    output logic [31:0] control_reg,
    output logic [7:0]  data_from_tx_fifo,
    input  logic        tx_fifo_rd_en,
    input  logic [7:0]  data_to_rx_fifo,
    input  logic        rx_fifo_wr_en
);

    logic [31:0]      r_readdata;
    logic [6:0]       r_slave_address;
    logic [31:0]      r_control;
    logic             r_tx_ov;
    logic             r_rx_ov;

    logic             w_wr;
    logic             w_rd;
    logic             w_tx_push;
    logic             w_rx_pop;
    logic             w_tx_full, w_tx_empty, w_tx_ovf;
    logic             w_rx_full, w_rx_empty, w_rx_ovf;
    logic [CNT_W-1:0] w_tx_count;
    logic [CNT_W-1:0] w_rx_count;
    logic [7:0]       w_rx_head;
    logic [7:0]       w_tx_head_unused;
    logic [7:0]       w_rx_dout_unused;
    logic             w_tx_ov_clr;
    logic             w_rx_ov_clr;
    logic [31:0]      w_status;

    assign w_wr      = chipselect & write;
    assign w_rd      = chipselect & read & ~w_wr;
    assign w_tx_push = w_wr & (address == REG_DATA) & byteenable[0];
    assign w_rx_pop  = w_rd & (address == REG_DATA);

    assign w_tx_ov_clr = w_wr & (address == REG_STATUS) & writedata[ST_TX_OV];
    assign w_rx_ov_clr = w_wr & (address == REG_STATUS) & writedata[ST_RX_OV];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clk      (clk),
        .resetn   (reset),
        .push     (w_tx_push),
        .pop      (tx_fifo_rd_en),
        .din      (writedata[7:0]),
        .dout     (data_from_tx_fifo),
        .head     (w_tx_head_unused),
        .full     (w_tx_full),
        .empty    (w_tx_empty),
        .count    (w_tx_count),
        .overflow (w_tx_ovf)
    );

    // RX data is taken from the combinational head so readdata lands one cycle after the read
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .clk      (clk),
        .resetn   (reset),
        .push     (rx_fifo_wr_en),
        .pop      (w_rx_pop),
        .din      (data_to_rx_fifo),
        .dout     (w_rx_dout_unused),
        .head     (w_rx_head),
        .full     (w_rx_full),
        .empty    (w_rx_empty),
        .count    (w_rx_count),
        .overflow (w_rx_ovf)
    );

    always_comb begin
        w_status                         = '0;
        w_status[ST_RX_EMPTY]            = w_rx_empty;
        w_status[ST_RX_FULL]             = w_rx_full;
        w_status[ST_RX_OV]               = r_rx_ov;
        w_status[ST_TX_EMPTY]            = w_tx_empty;
        w_status[ST_TX_FULL]             = w_tx_full;
        w_status[ST_TX_OV]               = r_tx_ov;
        w_status[ST_RX_COUNT +: CNT_W]   = w_rx_count;
        w_status[ST_TX_COUNT +: CNT_W]   = w_tx_count;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_readdata      <= '0;
            r_slave_address <= '0;
            r_control       <= '0;
            r_tx_ov         <= 1'b0;
            r_rx_ov         <= 1'b0;
        end else begin
            // Set wins over a same-cycle clear
            r_tx_ov <= w_tx_ovf | (r_tx_ov & ~w_tx_ov_clr);
            r_rx_ov <= w_rx_ovf | (r_rx_ov & ~w_rx_ov_clr);

            r_control[CTRL_START_BIT] <= 1'b0;
            if (w_wr && address == REG_CONTROL) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) begin
                        r_control[8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end
            if (w_wr && address == REG_ADDRESS && byteenable[0]) begin
                r_slave_address <= writedata[6:0];
            end

            if (w_rd) begin
                case (address)
                    REG_ADDRESS: r_readdata <= {25'd0, r_slave_address};
                    REG_DATA:    r_readdata <= w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
                    REG_STATUS:  r_readdata <= w_status;
                    default:     r_readdata <= r_control;
                endcase
            end
        end
    end

    assign readdata      = r_readdata;
    assign slave_address = r_slave_address;
    assign control_reg   = r_control;

endmodule

// File: tb/tb_i2c_reg_fifo_if.sv
// tb/tb_i2c_reg_fifo_if.sv - self-checking bench for i2c_reg_fifo_if
module tb_i2c_reg_fifo_if;

    localparam logic [1:0] A_ADDR = 2'd0;
    localparam logic [1:0] A_DATA = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  slave_address;
    logic [31:0] control_reg;
    logic [7:0]  data_from_tx_fifo;
    logic        tx_fifo_rd_en;
    logic [7:0]  data_to_rx_fifo;
    logic        rx_fifo_wr_en;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[11];

    i2c_reg_fifo_if #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .byteenable        (byteenable),
        .chipselect        (chipselect),
        .read              (read),
        .write             (write),
        .writedata         (writedata),
        .readdata          (readdata),
        .slave_address     (slave_address),
        .control_reg       (control_reg),
        .data_from_tx_fifo (data_from_tx_fifo),
        .tx_fifo_rd_en     (tx_fifo_rd_en),
        .data_to_rx_fifo   (data_to_rx_fifo),
        .rx_fifo_wr_en     (rx_fifo_wr_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 0; read = 0; write = 0; byteenable = 0; writedata = 0;
        address = 0; tx_fifo_rd_en = 0; rx_fifo_wr_en = 0; data_to_rx_fifo = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        chipselect = 1; write = 1; address = a; byteenable = be; writedata = d;
        tick();
        idle();
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        chipselect = 1; read = 1; address = a;
        exp_q.push_back(exp);
        tick();
        idle();
        check(name, readdata, exp_q.pop_front());
    endtask

    task automatic tx_pop(input string name);
        tx_fifo_rd_en = 1;
        tick();
        idle();
        check(name, {24'd0, data_from_tx_fifo}, {24'd0, tx_q.pop_front()});
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_fifo_wr_en = 1; data_to_rx_fifo = b;
        tick();
        idle();
    endtask

    initial begin
        vecs[0]  = '{1, 0, A_ADDR, 4'b0001, 32'h1234_5650, 0, 32'h0,         "addr_wr"};
        vecs[1]  = '{0, 1, A_ADDR, 4'b0000, 32'h0,         1, 32'h50,        "addr_rd"};
        vecs[2]  = '{1, 0, A_ADDR, 4'b0000, 32'h7F,        0, 32'h0,         "addr_wr_nobe"};
        vecs[3]  = '{0, 1, A_ADDR, 4'b0000, 32'h0,         1, 32'h50,        "addr_rd_hold"};
        vecs[4]  = '{1, 0, A_CTRL, 4'b0011, 32'hFFFF_1234, 0, 32'h0,         "ctrl_wr_lo"};
        vecs[5]  = '{0, 1, A_CTRL, 4'b0000, 32'h0,         1, 32'h0000_1234, "ctrl_rd_lo"};
        vecs[6]  = '{1, 0, A_CTRL, 4'b1100, 32'h5A00_0000, 0, 32'h0,         "ctrl_wr_hi"};
        vecs[7]  = '{0, 1, A_CTRL, 4'b0000, 32'h0,         1, 32'h5A00_1234, "ctrl_rd_hi"};
        vecs[8]  = '{0, 1, A_DATA, 4'b0000, 32'h0,         1, 32'h0,         "data_rd_empty"};
        vecs[9]  = '{1, 1, A_ADDR, 4'b0001, 32'h22,        1, 32'h0,         "wr_rd_same_holds"};
        vecs[10] = '{0, 1, A_ADDR, 4'b0000, 32'h0,         1, 32'h22,        "addr_rd_after_both"};

        idle();
        reset = 0;
        tick();
        tick();
        check("rst_readdata", readdata, 32'h0);
        check("rst_slave_addr", {25'd0, slave_address}, 32'h0);
        check("rst_control", control_reg, 32'h0);
        check("rst_tx_data", {24'd0, data_from_tx_fifo}, 32'h0);
        reset = 1;
        bus_read(A_STAT, 32'h0000_0009, "rst_status");

        foreach (vecs[i]) begin
            chipselect = 1; write = vecs[i].wr; read = vecs[i].rd;
            address = vecs[i].addr; byteenable = vecs[i].be; writedata = vecs[i].wdata;
            if (vecs[i].chk) exp_q.push_back(vecs[i].exp);
            tick();
            idle();
            if (vecs[i].chk) check(vecs[i].name, readdata, exp_q.pop_front());
        end
        check("slave_addr_port", {25'd0, slave_address}, 32'h22);

        // START self-clear and address
        bus_write(A_CTRL, 4'b1111, 32'h00A2_0085);
        check("ctrl_start_set", control_reg, 32'h00A2_0085);
        tick();
        check("ctrl_start_clr", control_reg, 32'h00A0_0085);
        bus_read(A_CTRL, 32'h00A0_0085, "ctrl_rd_after_start");
        bus_write(A_ADDR, 4'b0001, 32'h50);
        check("slave_addr_50", {25'd0, slave_address}, 32'h50);

        // TX path
        bus_write(A_DATA, 4'b0001, 32'hA5); tx_q.push_back(8'hA5);
        bus_write(A_DATA, 4'b0001, 32'h3C); tx_q.push_back(8'h3C);
        bus_read(A_STAT, 32'h0002_0001, "tx_count2");
        tx_pop("tx_pop_a5");
        repeat (3) tick();
        check("tx_hold_a5", {24'd0, data_from_tx_fifo}, 32'hA5);
        bus_read(A_STAT, 32'h0001_0001, "tx_count1");
        tx_pop("tx_pop_3c");
        bus_read(A_STAT, 32'h0000_0009, "tx_count0");
        tx_fifo_rd_en = 1; tick(); idle();
        check("tx_pop_empty_hold", {24'd0, data_from_tx_fifo}, 32'h3C);
        bus_read(A_STAT, 32'h0000_0009, "tx_pop_empty_status");

        // push and pop together on an empty TX FIFO: push only
        chipselect = 1; write = 1; address = A_DATA; byteenable = 4'b0001; writedata = 32'h5E;
        tx_fifo_rd_en = 1; tx_q.push_back(8'h5E);
        tick(); idle();
        check("tx_empty_pushpop_hold", {24'd0, data_from_tx_fifo}, 32'h3C);
        bus_read(A_STAT, 32'h0001_0001, "tx_empty_pushpop_cnt");
        tx_pop("tx_pop_5e");

        // TX overflow
        for (int i = 0; i <= 16; i++) begin
            bus_write(A_DATA, 4'b0001, 32'(i));
            if (i < 16) tx_q.push_back(8'(i));
        end
        bus_read(A_STAT, 32'h0010_0031, "tx_ov_status");
        bus_write(A_STAT, 4'b1111, 32'h20);
        bus_read(A_STAT, 32'h0010_0011, "tx_ov_cleared");

        // full TX with write and pop in the same cycle
        chipselect = 1; write = 1; address = A_DATA; byteenable = 4'b0001; writedata = 32'h77;
        tx_fifo_rd_en = 1; tx_q.push_back(8'h77);
        tick(); idle();
        check("tx_full_pushpop_out", {24'd0, data_from_tx_fifo}, {24'd0, tx_q.pop_front()});
        bus_read(A_STAT, 32'h0010_0011, "tx_full_pushpop_status");
        for (int i = 0; i < 16; i++) tx_pop($sformatf("tx_drain_%0d", i));
        bus_read(A_STAT, 32'h0000_0009, "tx_drained");

        // RX path
        rx_push(8'h11);
        rx_push(8'h22);
        bus_read(A_STAT, 32'h0000_0208, "rx_count2");
        bus_read(A_DATA, 32'h11, "rx_rd_11");
        bus_read(A_DATA, 32'h22, "rx_rd_22");
        bus_read(A_DATA, 32'h00, "rx_rd_empty");
        bus_read(A_STAT, 32'h0000_0009, "rx_empty_status");

        // RX overflow, simultaneous ops on full, set-beats-clear
        for (int i = 0; i <= 16; i++) rx_push(8'(8'h80 + i));
        bus_read(A_STAT, 32'h0000_100E, "rx_ov_status");
        bus_write(A_STAT, 4'b1111, 32'h04);
        bus_read(A_STAT, 32'h0000_100A, "rx_ov_cleared");
        chipselect = 1; read = 1; address = A_DATA;
        rx_fifo_wr_en = 1; data_to_rx_fifo = 8'h99;
        exp_q.push_back(32'h80);
        tick(); idle();
        check("rx_full_pushpop_rd", readdata, exp_q.pop_front());
        bus_read(A_STAT, 32'h0000_100A, "rx_full_pushpop_status");
        chipselect = 1; write = 1; address = A_STAT; byteenable = 4'b1111; writedata = 32'h04;
        rx_fifo_wr_en = 1; data_to_rx_fifo = 8'h9A;
        tick(); idle();
        bus_read(A_STAT, 32'h0000_100E, "rx_ov_set_wins");

        // reset in the middle of a burst
        bus_write(A_DATA, 4'b0001, 32'h42);
        bus_write(A_CTRL, 4'b1111, 32'h0002_0001);
        chipselect = 1; write = 1; address = A_DATA; byteenable = 4'b0001; writedata = 32'h43;
        rx_fifo_wr_en = 1; data_to_rx_fifo = 8'h55; tx_fifo_rd_en = 1;
        reset = 0;
        tick();
        idle();
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_control", control_reg, 32'h0);
        check("mid_rst_slave_addr", {25'd0, slave_address}, 32'h0);
        check("mid_rst_tx_data", {24'd0, data_from_tx_fifo}, 32'h0);
        reset = 1;
        bus_read(A_STAT, 32'h0000_0009, "mid_rst_status");
        bus_read(A_DATA, 32'h0, "mid_rst_rx_empty");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
